// File: rtl/shift_sub_divider_pkg.sv
// Shared constants for the shift-subtract divider and its BCD display path.
package shift_sub_divider_pkg;

  localparam int WN_DEF = 16;
  localparam int WD_DEF = 8;
  localparam int BCD_W  = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Operand-load / start / done bus between a requester and the divider.
interface shift_sub_divider_if
  import shift_sub_divider_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WD = WD_DEF
);
  // Handshake: start is a level request sampled only in IDLE. done stays high
  // while the result is held. A new division requires start to drop and rise.
  logic              start;
  logic [WN-1:0]     a;
  logic [WD-1:0]     b;
  logic              load_a;
  logic              load_b;
  logic [WN-1:0]     q;
  logic [WD-1:0]     r;
  logic              done;
  logic              div_zero;
  logic [BCD_W-1:0]  q_BCD;
  logic [1:0]        state;

  modport master (
    output start, a, b, load_a, load_b,
    input  q, r, done, div_zero, q_BCD, state
  );

  modport slave (
    input  start, a, b, load_a, load_b,
    output q, r, done, div_zero, q_BCD, state
  );
endinterface

// File: rtl/bin16_to_bcd20.sv
// Combinational double-dabble: 16-bit binary to five BCD digits.
module bin16_to_bcd20
  import shift_sub_divider_pkg::*;
(
  input  logic [15:0]      bin,
  output logic [BCD_W-1:0] bcd
);

  logic [35:0] sh;

  always_comb begin
    sh = {20'b0, bin};
    for (int i = 0; i < 16; i++) begin
      // Adjust each digit before the shift so it carries correctly into the next.
      for (int d = 0; d < 5; d++) begin
        if (sh[16+4*d +: 4] >= 4'd5) sh[16+4*d +: 4] = sh[16+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    bcd = sh[35:16];
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one quotient bit per clock, result latched on completion.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WD = WD_DEF
)(
  input  logic                clk_10kHz,
  input  logic                clrn,
  shift_sub_divider_if.slave  bus
);

  localparam int CW = $clog2(WN + 1);

  state_t           state_q, state_d;
  logic [WN-1:0]    a_reg, qsh, q_reg;
  logic [WD-1:0]    b_reg, r_reg;
  logic [WD:0]      rem;
  logic [CW-1:0]    cnt;
  logic             dz;
  logic [WD:0]      t, rem_nx;
  logic             ge;
  logic [BCD_W-1:0] q_bcd;

  // One restoring step: shift the next dividend bit in and try the subtraction.
  always_comb begin
    t      = {rem[WD-1:0], qsh[WN-1]};
    ge     = (t >= {1'b0, b_reg});
    rem_nx = ge ? (t - {1'b0, b_reg}) : t;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = bus.start ? ((b_reg != '0) ? S_CALC : S_DONE) : S_IDLE;
      S_CALC:  state_d = (cnt == CW'(1)) ? S_DONE : S_CALC;
      S_DONE:  state_d = bus.start ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_10kHz or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_10kHz or negedge clrn) begin
    if (!clrn) begin
      a_reg <= '0;
      b_reg <= '0;
      qsh   <= '0;
      rem   <= '0;
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
      dz    <= 1'b0;
    end else begin
      // Operands are frozen while an iteration is running.
      if (state_q != S_CALC) begin
        if (bus.load_a) a_reg <= bus.a;
        if (bus.load_b) b_reg <= bus.b;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (b_reg != '0) begin
              qsh <= a_reg;
              rem <= '0;
              cnt <= CW'(WN);
              dz  <= 1'b0;
            end else begin
              q_reg <= '1;
              r_reg <= '0;
              dz    <= 1'b1;
            end
          end
        end
        S_CALC: begin
          qsh <= {qsh[WN-2:0], ge};
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            q_reg <= {qsh[WN-2:0], ge};
            r_reg <= rem_nx[WD-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  bin16_to_bcd20 u_bcd (
    .bin (q_reg),
    .bcd (q_bcd)
  );

  assign bus.q        = q_reg;
  assign bus.r        = r_reg;
  assign bus.done     = (state_q == S_DONE);
  assign bus.div_zero = dz;
  assign bus.q_BCD    = q_bcd;
  assign bus.state    = state_q;

endmodule
